// File: rtl/updown_counter_core.sv
// Up/down counter engine with tick prescaler, run/stop FSM, parallel load and boundary pulse.
// Optional ping-pong boundary behaviour is enabled by defining UDC_BOUNCE_EN.
module updown_counter_core #(
  parameter int unsigned MAX_COUNT = 9999,
  parameter int unsigned TICK_DIV  = 10_000_000,
  localparam int unsigned CNT_W    = $clog2(MAX_COUNT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_mode,
  input  logic             btn_run_stop,
  input  logic             btn_clear,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count,
  output logic             running,
  output logic             dir_down,
  output logic             wrap,
  output logic [3:0]       led
);

  localparam int unsigned PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_COUNT);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRESC_ONE  = PW'(1);

  typedef enum logic {STOP = 1'b0, RUN = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [PW-1:0]    presc, presc_nxt;
  logic [CNT_W-1:0] count_nxt;
  logic             dir_nxt, wrap_nxt, tick, at_bound, bounce;

  always_comb begin
    tick      = (state == RUN) && (presc == PRESC_LAST);
    at_bound  = dir_down ? (count == '0) : (count == MAX_C);
    state_nxt = state;
    if (btn_run_stop) begin
      case (state)
        STOP:    state_nxt = RUN;
        default: state_nxt = STOP;
      endcase
    end

    presc_nxt = presc;
    if (btn_clear || load || tick) presc_nxt = '0;
    else if (state == RUN)         presc_nxt = presc + PRESC_ONE;

    count_nxt = count;
    wrap_nxt  = 1'b0;
    bounce    = 1'b0;
    if (btn_clear) begin
      count_nxt = '0;
    end else if (load) begin
      count_nxt = (load_val > MAX_C) ? MAX_C : load_val;
    end else if (tick) begin
      if (at_bound) begin
        wrap_nxt = 1'b1;
`ifdef UDC_BOUNCE_EN
        count_nxt = dir_down ? ONE_C : (MAX_C - ONE_C);
        bounce    = 1'b1;
`else
        count_nxt = dir_down ? MAX_C : '0;
`endif
      end else begin
        count_nxt = dir_down ? (count - ONE_C) : (count + ONE_C);
      end
    end

    // Boundary reversal and the mode button each flip direction; both compose as XOR.
    dir_nxt = dir_down ^ btn_mode ^ bounce;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= STOP;
      presc    <= '0;
      count    <= '0;
      dir_down <= 1'b0;
      wrap     <= 1'b0;
      running  <= 1'b0;
      led      <= 4'b0001;
    end else begin
      state    <= state_nxt;
      presc    <= presc_nxt;
      count    <= count_nxt;
      dir_down <= dir_nxt;
      wrap     <= wrap_nxt;
      running  <= (state_nxt == RUN);
      led      <= {(state_nxt == RUN) &  dir_nxt, (state_nxt == RUN) & ~dir_nxt,
                   (state_nxt == STOP) &  dir_nxt, (state_nxt == STOP) & ~dir_nxt};
    end
  end

endmodule
